// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader: framed serial configuration loader.
// Receives start bit + 27 payload bits + trailer. The payload is held in a shadow register
// and copied atomically to the active outputs only after the trailer has been validated.
// A stalled frame aborts after TIMEOUT consecutive idle (en=0) cycles.
module cfg_frame_loader #(
  parameter int                   TRAILER_W = 5,
  parameter logic [TRAILER_W-1:0] TRAILER   = 5'b01010,
  parameter int                   TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       serial_in,
  output logic       out_sel,
  output logic       clk_sel,
  output logic [4:0] jump1,
  output logic [4:0] jump2,
  output logic [4:0] jump3,
  output logic [4:0] jump4,
  output logic [4:0] jump5,
  output logic       finished,
  output logic       busy,
  output logic       cfg_err
);

  localparam int PAYLOAD_W = 27;
  localparam int CNT_W     = 5;
  localparam int TO_W      = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_TRAILER,
    ST_COMMIT
  } state_t;

  state_t                 state_reg, state_next;
  logic [PAYLOAD_W-1:0]   shadow_reg, shadow_next;
  logic [PAYLOAD_W-1:0]   active_reg, active_next;
  logic [TRAILER_W-1:0]   trailer_reg, trailer_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [TO_W-1:0]        to_cnt_reg, to_cnt_next;
  logic                   finished_reg, finished_next;
  logic                   err_reg, err_next;

  // Trailer register with the current bit shifted in; the MSB of the wide
  // concatenation falls off so only the most recent TRAILER_W bits remain.
  logic [TRAILER_W:0]     trl_wide;
  logic [TRAILER_W-1:0]   trl_shift;

  assign trl_wide  = {trailer_reg, serial_in};
  assign trl_shift = trl_wide[TRAILER_W-1:0];

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      shadow_reg   <= '0;
      active_reg   <= '0;
      trailer_reg  <= '0;
      bit_cnt_reg  <= '0;
      to_cnt_reg   <= '0;
      finished_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shadow_reg   <= shadow_next;
      active_reg   <= active_next;
      trailer_reg  <= trailer_next;
      bit_cnt_reg  <= bit_cnt_next;
      to_cnt_reg   <= to_cnt_next;
      finished_reg <= finished_next;
      err_reg      <= err_next;
    end
  end

  // Next-state logic: framing, trailer check, idle timeout and commit.
  always_comb begin
    state_next    = state_reg;
    shadow_next   = shadow_reg;
    active_next   = active_reg;
    trailer_next  = trailer_reg;
    bit_cnt_next  = bit_cnt_reg;
    to_cnt_next   = to_cnt_reg;
    finished_next = finished_reg;
    err_next      = err_reg;

    case (state_reg)
      ST_IDLE: begin
        // A qualified '1' is the start bit; qualified '0's are line idle.
        if (en && serial_in) begin
          state_next   = ST_PAYLOAD;
          bit_cnt_next = '0;
          to_cnt_next  = '0;
        end
      end

      ST_PAYLOAD, ST_TRAILER: begin
        if (!en) begin
          // Stalled mid-frame: abort once TIMEOUT idle cycles have accumulated.
          if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
            err_next     = 1'b1;
            state_next   = ST_IDLE;
            to_cnt_next  = '0;
            bit_cnt_next = '0;
          end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
          end
        end else begin
          to_cnt_next = '0;
          if (state_reg == ST_PAYLOAD) begin
            shadow_next = {shadow_reg[PAYLOAD_W-2:0], serial_in};
            if (bit_cnt_reg == CNT_W'(PAYLOAD_W - 1)) begin
              state_next   = ST_TRAILER;
              bit_cnt_next = '0;
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end else begin
            trailer_next = trl_shift;
            if (bit_cnt_reg == CNT_W'(TRAILER_W - 1)) begin
              bit_cnt_next = '0;
              if (trl_shift == TRAILER) begin
                state_next = ST_COMMIT;
              end else begin
                // Bad trailer: drop the shadow contents, keep live config.
                err_next   = 1'b1;
                state_next = ST_IDLE;
              end
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end
        end
      end

      ST_COMMIT: begin
        active_next   = shadow_reg;
        finished_next = 1'b1;
        err_next      = 1'b0;
        state_next    = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign out_sel  = active_reg[26];
  assign clk_sel  = active_reg[25];
  assign jump1    = active_reg[24:20];
  assign jump2    = active_reg[19:15];
  assign jump3    = active_reg[14:10];
  assign jump4    = active_reg[9:5];
  assign jump5    = active_reg[4:0];
  assign finished = finished_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign cfg_err  = err_reg;

endmodule

// File: doc/cfg_frame_loader.md
Name: cfg_frame_loader

Overview:
- Serial configuration controller for the latency FSM datapath.
- Receives a framed bitstream on one pin and deserialises the clock-select bit, the output-select bit and five 5-bit jump states.
- Validates the frame trailer, then commits the configuration atomically and raises `finished` to release the state machine.
- Replaces the free-running shift-in loader: adds framing, error detection, a timeout, and shadow/active registers so live config never changes mid-load.

Parameters:
- TRAILER_W, 5, trailer width in bits.
- TRAILER, 5'b01010, required trailer pattern, MSB received first.
- TIMEOUT, 64, consecutive `en`-low cycles tolerated mid-frame before abort (≥2).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  bit-valid qualifier; `serial_in` is sampled only when `en`=1.
- serial_in  in  1  serial configuration data.
- out_sel  out  1  active output-select bit.
- clk_sel  out  1  active clock-select bit.
- jump1..jump5  out  5 each  active jump states.
- finished  out  1  a valid configuration is committed.
- busy  out  1  a frame is in progress (state is not IDLE).
- cfg_err  out  1  sticky: last frame failed trailer check or timed out.

Behaviour:
- Reset (`rst`=1 at the edge):
  - State = IDLE.
  - All active and shadow registers = 0; `finished`=0, `busy`=0, `cfg_err`=0.
  - Bit counter and timeout counter = 0.
  - `rst` overrides every other input, including mid-frame.
- Frame format, in received order:
  - 1 start bit (=1).
  - 27 payload bits: `out_sel`, `clk_sel`, jump1[4:0], jump2[4:0], jump3[4:0], jump4[4:0], jump5[4:0], each field MSB first.
  - TRAILER_W trailer bits.
  - Total 33 qualified bits.
- State machine:
  - IDLE: on `en`=1 and `serial_in`=1, go to PAYLOAD. Counter = 0, timeout = 0. `en`=1 with `serial_in`=0 is ignored (line idle).
  - PAYLOAD:
    - Each qualified bit shifts into the 27-bit shadow register (left shift, LSB-in); counter increments.
    - When the 27th bit is taken, go to TRAILER with counter = 0.
  - TRAILER:
    - Each qualified bit shifts into the trailer register.
    - On the TRAILER_W-th bit, compare {trailer_reg, bit} with TRAILER.
    - Match: go to COMMIT.
    - Mismatch: set `cfg_err`=1, go to IDLE. The shadow register is discarded and active outputs are unchanged.
  - COMMIT (1 cycle):
    - Copy shadow to active registers, set `finished`=1, clear `cfg_err`, go to IDLE.
    - `en`/`serial_in` in this cycle are ignored.
    - New config is visible on outputs one cycle after the last trailer bit is sampled.
- Timeout:
  - In PAYLOAD or TRAILER, each `en`=0 cycle increments the timeout counter; any `en`=1 cycle clears it.
  - When the counter reaches TIMEOUT: set `cfg_err`=1 and go to IDLE. Active outputs and `finished` are unchanged.
  - Timeout is not active in IDLE.
- Reload:
  - A new start bit in IDLE while `finished`=1 begins a new frame.
  - `finished` stays 1 and the active outputs hold the old config until the next COMMIT.
  - A failed reload leaves `finished`=1 with the old config and sets `cfg_err`.
- `busy` = (state != IDLE), registered with the state.
- `cfg_err` is sticky and cleared only by `rst` or a successful COMMIT.

Test Plan:
- Reset then frame 1, {1,0, 5'd1,5'd2,5'd3,5'd4,5'd5}, 01010 with `en`=1 every cycle:
  - `busy`=1 from the cycle after the start bit.
  - One cycle after the 33rd bit: `out_sel`=1, `clk_sel`=0, jump1..5=1..5, `finished`=1, `cfg_err`=0.
- Same frame with trailer 01011:
  - `cfg_err`=1, `finished`=0, all outputs remain 0, `busy`=0 after the last bit.
- Loaded config (1..5), then reload frame {0,1, 5'd31,5'd0,5'd31,5'd0,5'd31}, 01010 with `en` toggling 1/0:
  - Outputs hold 1..5 during the load; then switch to 31,0,31,0,31 with `clk_sel`=1.
  - `finished` stays 1 throughout.
- Start a frame, send 10 payload bits, hold `en`=0 for 64 cycles:
  - `cfg_err`=1 and IDLE at cycle 64; outputs unchanged.
  - Repeat with 63 idle cycles then complete the frame: commit succeeds.
- Assert `rst` at payload bit 20:
  - Next cycle all outputs, `finished`, `busy`, `cfg_err` = 0.
  - A subsequent full valid frame loads correctly.
- `serial_in`=0 with `en`=1 for 40 cycles in IDLE:
  - `busy` stays 0, no state change, `cfg_err` stays 0.
